sync_fifo_prog: RTL and testbench
=================================

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 7: DEPTH = 2^ADDR_WIDTH words (128).
REQ-003 The block SHALL have parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-006 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port flush  input  1  synchronous clear of contents and sticky flags.
REQ-008 The block SHALL have port wr_en  input  1  write request.
REQ-009 The block SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-010 The block SHALL have port rd_en  input  1  read request (pop).
REQ-011 The block SHALL have port afull_th  input  ADDR_WIDTH+1  almost-full threshold.
REQ-012 The block SHALL have port aempty_th  input  ADDR_WIDTH+1  almost-empty threshold.
REQ-013 The block SHALL have port rd_data  output  DATA_WIDTH  read word.
REQ-014 The block SHALL have port rd_valid  output  1  rd_data holds a valid word.
REQ-015 The block SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 The block SHALL have port count  output  ADDR_WIDTH+1  words stored (0..DEPTH).
REQ-017 The block SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Pointers SHALL be ADDR_WIDTH+1 bits (wrap bit); count = wr_ptr - rd_ptr modulo 2^(ADDR_WIDTH+1).
REQ-019 full SHALL equal (count == DEPTH); empty SHALL equal (count == 0); both decoded from registered pointers.
REQ-020 almost_full SHALL equal (count >= afull_th); almost_empty SHALL equal (count <= aempty_th); thresholds sampled combinationally, unsigned.
REQ-021 A write SHALL be accepted iff wr_en && !full && !flush; accepted word stored at wr_ptr, wr_ptr increments, wrapping at 2^(ADDR_WIDTH+1).
REQ-022 A read SHALL be accepted iff rd_en && !empty && !flush; rd_ptr increments.
REQ-023 Simultaneous accepted read and write SHALL leave count unchanged; a write while full SHALL be dropped even if a read is accepted in the same cycle.
REQ-024 wr_en while full (no flush) SHALL set overflow; rd_en while empty (no flush) SHALL set underflow; both stay set until flush or reset.
REQ-025 FWFT=0: rd_data SHALL be registered, updated the cycle after an accepted read; rd_valid SHALL pulse high for exactly that cycle; rd_data holds otherwise.
REQ-026 FWFT=1: rd_data SHALL present the word at rd_ptr whenever !empty; rd_valid SHALL equal !empty; rd_en acknowledges and pops that word.
REQ-027 Write-to-read latency SHALL be one cycle: empty deasserts on the edge after the first accepted write into an empty FIFO.
REQ-028 flush SHALL have priority over wr_en/rd_en: next edge clears pointers, count, overflow, underflow, rd_valid; requests in the flush cycle are ignored without setting error flags.

Reset
REQ-029 While rstn is low, wr_ptr, rd_ptr, count, full, almost_full, overflow, underflow, rd_valid and rd_data SHALL be 0, and empty SHALL be 1; almost_empty SHALL be 1 for any aempty_th.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; memory array contents need not be cleared.

Structure
REQ-031 Shared constants (default widths, DEPTH derivation, mode encodings FWFT/standard) SHALL live in shared package fifo_pkg, reused by async_fifo successors.
REQ-032 Storage SHALL be a sub-module fifo_dpram (one write port, one read port, same clk; registered read for FWFT=0, asynchronous read for FWFT=1); pointer/flag logic stays in sync_fifo_prog.

Verification
REQ-033 The bench SHALL check: reset, then 128 writes of 0..127 (FWFT=0) -> full=1 after 128th edge, count=128, extra write sets overflow, data unchanged.
REQ-034 The bench SHALL check: read 128 words -> rd_data 0..127 in order, rd_valid one cycle after each rd_en, empty=1 at end, further rd_en sets underflow.
REQ-035 The bench SHALL check: 300 words with continuous simultaneous wr/rd around count=64 -> count constant, pointers wrap twice, no data loss or flags.
REQ-036 The bench SHALL check: afull_th=120, aempty_th=8 -> almost_full rises at count=120, almost_empty falls at count=9, both tracked on the way down.
REQ-037 The bench SHALL check: FWFT=1, single write 0xA5 -> next cycle rd_valid=1, rd_data=0xA5 without rd_en; rd_en pops, empty=1.
REQ-038 The bench SHALL check: flush at count=50 with overflow set and wr_en=1 -> next cycle count=0, empty=1, overflow=0, flush-cycle write not stored; rstn low mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared constants for the FIFO family (sync_fifo_prog today, async_fifo
//   variants later): default word/address widths, depth derivation and the
//   read-mode encodings.
//   No ports; import with "import fifo_pkg::*;".
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 7;

    // Read-mode encodings for the FWFT parameter.
    localparam int FWFT_STANDARD = 0;  // registered read, rd_valid pulses after a pop
    localparam int FWFT_ON       = 1;  // head word shown whenever the FIFO is not empty

    // Number of storage words for a given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog_if
//   Bundles the request/status signals of sync_fifo_prog.
//   Requests : flush, wr_en, wr_data, rd_en, afull_th, aempty_th
//   Status   : rd_data, rd_valid, full, empty, almost_full, almost_empty,
//              count, overflow, underflow
//   Debug    : dbg_wr_ptr, dbg_rd_ptr (internal pointers incl. wrap bit)
//
//   Handshake: a write is taken on a rising edge when wr_en && !full && !flush;
//   a read (pop) is taken when rd_en && !empty && !flush. full/empty act as the
//   inverse "ready" of each side. rd_valid marks rd_data as a valid word: in
//   standard mode it is high for the one cycle after a pop, in FWFT mode it is
//   high whenever a head word is presented. flush overrides both requests.
//
//   Modports: master = the user driving requests, slave = the FIFO.
// -----------------------------------------------------------------------------
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   afull_th;
    logic [ADDR_WIDTH:0]   aempty_th;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    logic [ADDR_WIDTH:0]   dbg_wr_ptr;
    logic [ADDR_WIDTH:0]   dbg_rd_ptr;

    modport master (
        output flush, wr_en, wr_data, rd_en, afull_th, aempty_th,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, dbg_wr_ptr, dbg_rd_ptr
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, afull_th, aempty_th,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, dbg_wr_ptr, dbg_rd_ptr
    );

endinterface

// File: rtl/fifo_dpram.sv
// -----------------------------------------------------------------------------
// fifo_dpram
//   Simple dual-port storage: one write port, one read port, single clock.
//   FWFT = FWFT_STANDARD : rd_data is a register loaded on rd_en (cleared by
//                          reset), so the word appears the cycle after a pop.
//   FWFT = FWFT_ON       : rd_data is an asynchronous read of rd_addr.
//   Ports:
//     clk, rstn        clock, async active-low reset (read register only)
//     wr_en, wr_addr, wr_data   write port
//     rd_en, rd_addr, rd_data   read port
//   The array itself is never reset.
// -----------------------------------------------------------------------------
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FWFT       = FWFT_STANDARD
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_async_read
            // Combinational read; the read enable and reset are not needed.
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = &{1'b0, rd_en, rstn};
            assign rd_data = mem[rd_addr];
        end else begin : g_reg_read
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with programmable almost-full / almost-empty thresholds,
//   sticky overflow/underflow flags, synchronous flush and selectable
//   standard / first-word-fall-through read mode.
//   Ports:
//     clk   rising-edge clock for all logic
//     rstn  asynchronous active-low reset
//     bus   sync_fifo_prog_if.slave (requests in, data/status out)
//   Storage lives in fifo_dpram; pointers and flags live here.
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FWFT       = FWFT_STANDARD
) (
    input logic             clk,
    input logic             rstn,
    sync_fifo_prog_if.slave bus
);

    // Pointers carry one extra wrap bit so that full (difference == DEPTH)
    // and empty (difference == 0) are distinguishable.
    localparam int                   PTR_WIDTH = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH_CNT = PTR_WIDTH'(fifo_depth(ADDR_WIDTH));
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  count_w;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // ---------------------------------------------------------------------
    // Status decode (purely from the registered pointers)
    // ---------------------------------------------------------------------
    assign count_w = wr_ptr - rd_ptr;
    assign full_w  = (count_w == DEPTH_CNT);
    assign empty_w = (count_w == '0);

    // full is evaluated before any same-cycle read, so a write while full is
    // dropped even when a pop happens in that cycle.
    assign wr_accept = bus.wr_en && !full_w  && !bus.flush;
    assign rd_accept = bus.rd_en && !empty_w && !bus.flush;

    // ---------------------------------------------------------------------
    // Pointers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sticky error flags: set by a refused request, cleared only by flush or
    // reset. Requests during a flush cycle never set them.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (mem_rdata)
    );

    // ---------------------------------------------------------------------
    // Read-side presentation
    // ---------------------------------------------------------------------
    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Head word is visible while anything is stored; forced to zero
            // when empty so reset/flush leave rd_data at 0.
            assign bus.rd_valid = !empty_w;
            assign bus.rd_data  = empty_w ? '0 : mem_rdata;
        end else begin : g_std
            logic rd_valid_q;

            // rd_accept is already low during flush, which clears the pulse.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                end
            end

            assign bus.rd_valid = rd_valid_q;
            assign bus.rd_data  = mem_rdata;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.count        = count_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_w >= bus.afull_th);
    assign bus.almost_empty = (count_w <= bus.aempty_th);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.dbg_wr_ptr   = wr_ptr;
    assign bus.dbg_rd_ptr   = rd_ptr;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
//   Bench for sync_fifo_prog: u_std (standard read) on bus0, u_fwft
//   (first-word-fall-through) on bus1. Inputs change and outputs are sampled
//   on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FWFT_STANDARD)) u_std (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FWFT_ON)) u_fwft (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    int              n_cmp = 0;
    int              n_err = 0;
    logic [DW-1:0]   mdl_q[$];   // words the model holds in the FIFO
    logic [DW-1:0]   exp_q[$];   // words expected on rd_data after a pop
    logic [DW-1:0]   fq[$];      // model of the FWFT instance
    logic            m_ovf  = 1'b0;
    logic            m_udf  = 1'b0;
    logic            m_racc = 1'b0;

    // ---------------------------------------------------------------------
    // Driver for the standard instance: updates the model, applies one
    // cycle of requests, returns on the following falling edge.
    // ---------------------------------------------------------------------
    task automatic drive0(input logic wr, input logic [DW-1:0] d, input logic rd, input logic fl);
        logic wacc;
        logic racc;
        wacc = wr && !fl && (mdl_q.size() != DEPTH);
        racc = rd && !fl && (mdl_q.size() != 0);
        if (fl) begin
            mdl_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr && !wacc) m_ovf = 1'b1;
            if (rd && !racc) m_udf = 1'b1;
        end
        if (racc) exp_q.push_back(mdl_q.pop_front());
        if (wacc) mdl_q.push_back(d);
        m_racc       = racc;
        bus0.wr_en   = wr;
        bus0.wr_data = d;
        bus0.rd_en   = rd;
        bus0.flush   = fl;
        @(posedge clk);
        @(negedge clk);
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        bus0.flush = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        logic [22:0] got;
        logic [22:0] want;
        bus0.flush = 0; bus0.wr_en = 0; bus0.rd_en = 0; bus0.wr_data = '0;
        bus1.flush = 0; bus1.wr_en = 0; bus1.rd_en = 0; bus1.wr_data = '0;
        bus0.afull_th  = 8'd120;
        bus1.afull_th  = 8'd120;
        bus0.aempty_th = 8'd0;
        bus1.aempty_th = 8'd0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        want = {8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        got  = {bus0.count, bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
                bus0.overflow, bus0.underflow, bus0.rd_valid, bus0.rd_data};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_std: got %h want %h", got, want);
        end
        got  = {bus1.count, bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
                bus1.overflow, bus1.underflow, bus1.rd_valid, bus1.rd_data};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_fwft: got %h want %h", got, want);
        end
        bus0.aempty_th = 8'd8;
        bus1.aempty_th = 8'd8;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [AW:0] ec;
        for (int i = 0; i < DEPTH; i++) begin
            drive0(1'b1, DW'(i), 1'b0, 1'b0);
            ec = (AW+1)'(mdl_q.size());
            n_cmp++;
            if (bus0.count !== ec || bus0.empty !== (ec == 0) || bus0.full !== (ec == 8'd128)) begin
                n_err++;
                $display("FAIL fill_count: got cnt=%0d e=%b f=%b want cnt=%0d", bus0.count, bus0.empty, bus0.full, ec);
            end
            n_cmp++;
            if (bus0.almost_full !== (ec >= 8'd120) || bus0.almost_empty !== (ec <= 8'd8)) begin
                n_err++;
                $display("FAIL fill_almost: cnt=%0d got af=%b ae=%b want af=%b ae=%b", ec,
                         bus0.almost_full, bus0.almost_empty, ec >= 8'd120, ec <= 8'd8);
            end
        end
        n_cmp++;
        if (bus0.full !== 1'b1 || bus0.count !== 8'd128) begin
            n_err++;
            $display("FAIL fill_full: got full=%b cnt=%0d want 1/128", bus0.full, bus0.count);
        end
        drive0(1'b1, 8'hFF, 1'b0, 1'b0);
        n_cmp++;
        if (bus0.overflow !== m_ovf || bus0.count !== 8'd128 || bus0.underflow !== m_udf) begin
            n_err++;
            $display("FAIL fill_overflow: got ovf=%b udf=%b cnt=%0d want ovf=%b udf=%b cnt=128",
                     bus0.overflow, bus0.underflow, bus0.count, m_ovf, m_udf);
        end
    endtask

    task automatic test_drain();
        logic [AW:0]   ec;
        logic [DW-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            drive0(1'b0, '0, 1'b1, 1'b0);
            exp = m_racc ? exp_q.pop_front() : 'x;
            n_cmp++;
            if (bus0.rd_valid !== m_racc || bus0.rd_data !== exp) begin
                n_err++;
                $display("FAIL drain_data: got v=%b d=%h want v=%b d=%h", bus0.rd_valid, bus0.rd_data, m_racc, exp);
            end
            ec = (AW+1)'(mdl_q.size());
            n_cmp++;
            if (bus0.count !== ec || bus0.almost_full !== (ec >= 8'd120) || bus0.almost_empty !== (ec <= 8'd8)) begin
                n_err++;
                $display("FAIL drain_flags: got cnt=%0d af=%b ae=%b want cnt=%0d", bus0.count,
                         bus0.almost_full, bus0.almost_empty, ec);
            end
        end
        drive0(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 8'd127 || bus0.empty !== 1'b1) begin
            n_err++;
            $display("FAIL drain_idle: got v=%b d=%h e=%b want 0/7f/1", bus0.rd_valid, bus0.rd_data, bus0.empty);
        end
        drive0(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (bus0.underflow !== m_udf || bus0.rd_valid !== 1'b0 || bus0.overflow !== m_ovf) begin
            n_err++;
            $display("FAIL drain_underflow: got udf=%b v=%b ovf=%b want udf=%b v=0 ovf=%b",
                     bus0.underflow, bus0.rd_valid, bus0.overflow, m_udf, m_ovf);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp;
        for (int i = 0; i < 50; i++) drive0(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        n_cmp++;
        if (bus0.count !== 8'd50 || bus0.overflow !== m_ovf) begin
            n_err++;
            $display("FAIL flush_pre: got cnt=%0d ovf=%b want 50/%b", bus0.count, bus0.overflow, m_ovf);
        end
        drive0(1'b1, 8'hEE, 1'b0, 1'b1);
        n_cmp++;
        if (bus0.count !== 8'd0 || bus0.empty !== 1'b1 || bus0.overflow !== 1'b0 ||
            bus0.underflow !== 1'b0 || bus0.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: got cnt=%0d e=%b ovf=%b udf=%b v=%b want 0/1/0/0/0",
                     bus0.count, bus0.empty, bus0.overflow, bus0.underflow, bus0.rd_valid);
        end
        // A pop request on an empty FIFO during flush must not raise underflow.
        drive0(1'b0, '0, 1'b1, 1'b1);
        n_cmp++;
        if (bus0.underflow !== 1'b0 || bus0.empty !== 1'b1) begin
            n_err++;
            $display("FAIL flush_noerr: got udf=%b e=%b want 0/1", bus0.underflow, bus0.empty);
        end
        drive0(1'b1, 8'h5A, 1'b0, 1'b0);
        drive0(1'b0, '0, 1'b1, 1'b0);
        exp = m_racc ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp) begin
            n_err++;
            $display("FAIL flush_after: got v=%b d=%h want v=1 d=%h", bus0.rd_valid, bus0.rd_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        logic [AW-1:0] prev;
        logic [AW-1:0] cur;
        logic [AW:0]   diff;
        int            wraps;
        for (int i = 0; i < 64; i++) drive0(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        wraps = 0;
        prev  = bus0.dbg_rd_ptr[AW-1:0];
        for (int i = 0; i < 300; i++) begin
            drive0(1'b1, DW'($urandom_range(0, 255)), 1'b1, 1'b0);
            exp = m_racc ? exp_q.pop_front() : 'x;
            n_cmp++;
            if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp) begin
                n_err++;
                $display("FAIL b2b_data[%0d]: got v=%b d=%h want v=1 d=%h", i, bus0.rd_valid, bus0.rd_data, exp);
            end
            n_cmp++;
            if (bus0.count !== 8'd64 ||
                {bus0.full, bus0.empty, bus0.overflow, bus0.underflow} !== 4'b0000) begin
                n_err++;
                $display("FAIL b2b_status[%0d]: got cnt=%0d f/e/o/u=%b want 64/0000", i, bus0.count,
                         {bus0.full, bus0.empty, bus0.overflow, bus0.underflow});
            end
            cur = bus0.dbg_rd_ptr[AW-1:0];
            if (cur < prev) wraps++;
            prev = cur;
        end
        diff = bus0.dbg_wr_ptr - bus0.dbg_rd_ptr;
        n_cmp++;
        if (wraps < 2 || diff !== 8'd64) begin
            n_err++;
            $display("FAIL b2b_wrap: got wraps=%0d ptr_diff=%0d want >=2/64", wraps, diff);
        end
        for (int i = 0; i < 64; i++) begin
            drive0(1'b0, '0, 1'b1, 1'b0);
            exp = m_racc ? exp_q.pop_front() : 'x;
            n_cmp++;
            if (bus0.rd_data !== exp) begin
                n_err++;
                $display("FAIL b2b_drain[%0d]: got %h want %h", i, bus0.rd_data, exp);
            end
        end
    endtask

    task automatic test_fwft();
        n_cmp++;
        if (bus1.rd_valid !== 1'b0 || bus1.empty !== 1'b1) begin
            n_err++;
            $display("FAIL fwft_idle: got v=%b e=%b want 0/1", bus1.rd_valid, bus1.empty);
        end
        bus1.wr_en = 1'b1; bus1.wr_data = 8'hA5; fq.push_back(8'hA5);
        @(posedge clk); @(negedge clk);
        bus1.wr_en = 1'b0;
        repeat (2) begin
            // Checked twice: without rd_en the head word must stay presented.
            n_cmp++;
            if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== fq[0] || bus1.empty !== 1'b0) begin
                n_err++;
                $display("FAIL fwft_head: got v=%b d=%h e=%b want 1/%h/0", bus1.rd_valid, bus1.rd_data, bus1.empty, fq[0]);
            end
            @(negedge clk);
        end
        bus1.rd_en = 1'b1; void'(fq.pop_front());
        @(posedge clk); @(negedge clk);
        bus1.rd_en = 1'b0;
        n_cmp++;
        if (bus1.empty !== 1'b1 || bus1.rd_valid !== 1'b0 || bus1.count !== 8'd0) begin
            n_err++;
            $display("FAIL fwft_pop: got e=%b v=%b cnt=%0d want 1/0/0", bus1.empty, bus1.rd_valid, bus1.count);
        end
        for (int i = 0; i < 2; i++) begin
            bus1.wr_en = 1'b1; bus1.wr_data = DW'(8'hB1 + i); fq.push_back(DW'(8'hB1 + i));
            @(posedge clk); @(negedge clk);
        end
        bus1.wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== fq[0]) begin
                n_err++;
                $display("FAIL fwft_seq[%0d]: got v=%b d=%h want 1/%h", i, bus1.rd_valid, bus1.rd_data, fq[0]);
            end
            bus1.rd_en = 1'b1; void'(fq.pop_front());
            @(posedge clk); @(negedge clk);
            bus1.rd_en = 1'b0;
        end
        n_cmp++;
        if (bus1.empty !== 1'b1 || bus1.rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL fwft_end: got e=%b d=%h want 1/00", bus1.empty, bus1.rd_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0]   got;
        logic [22:0]   want;
        logic [DW-1:0] exp;
        for (int i = 0; i < 10; i++) drive0(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        drive0(1'b1, 8'h4A, 1'b1, 1'b0);
        exp = m_racc ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (bus0.rd_data !== exp) begin
            n_err++;
            $display("FAIL midrst_pre: got %h want %h", bus0.rd_data, exp);
        end
        bus1.wr_en = 1'b1; bus1.wr_data = 8'h66;
        bus0.wr_en = 1'b1; bus0.wr_data = 8'h77;
        #2;
        rstn = 1'b0;
        #1;
        want = {8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        got  = {bus0.count, bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
                bus0.overflow, bus0.underflow, bus0.rd_valid, bus0.rd_data};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL midrst_std: got %h want %h", got, want);
        end
        n_cmp++;
        if (bus1.empty !== 1'b1 || bus1.rd_valid !== 1'b0 || bus1.count !== 8'd0) begin
            n_err++;
            $display("FAIL midrst_fwft: got e=%b v=%b cnt=%0d want 1/0/0", bus1.empty, bus1.rd_valid, bus1.count);
        end
        bus0.wr_en = 1'b0;
        bus1.wr_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mdl_q.delete();
        exp_q.delete();
        fq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        drive0(1'b1, 8'h3C, 1'b0, 1'b0);
        drive0(1'b0, '0, 1'b1, 1'b0);
        exp = m_racc ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp || bus0.empty !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_after: got v=%b d=%h e=%b want 1/%h/1", bus0.rd_valid, bus0.rd_data, bus0.empty, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Sequencer and report
    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_flush();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sequence still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
